// File: rtl/fifo_sync_hs.sv
// rtl/fifo_sync_hs.sv - single-clock valid/ready FIFO with FWFT or registered read, level and flags
//
// Optional feature macro: FIFO_HWM_EN (adds hwm_clr / hwm high-water-mark tracking)
// Ports:
//   clk, rst (synchronous, active-high), flush (synchronous clear)
//   in_valid / in_ready / in_data       write side
//   out_valid / out_ready / out_data    read side (out_ready = pop in FWFT, read request otherwise)
//   level, almost_full, almost_empty    occupancy and threshold flags
//   hwm_clr, hwm                        high-water mark (FIFO_HWM_EN only)
module fifo_sync_hs #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 1,
   parameter int AFULL_TH   = DEPTH - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      almost_full,
   output logic                      almost_empty
`ifdef FIFO_HWM_EN
   ,
   input  logic                      hwm_clr,
   output logic [$clog2(DEPTH):0]    hwm
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_sync_hs: DEPTH must be a power of two >= 2");
   end
   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("fifo_sync_hs: AFULL_TH must be in 1..DEPTH");
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_sync_hs: AEMPTY_TH must be in 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         level_next;
   logic                  empty;
   logic                  full;
   logic                  wr_en;
   logic                  rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // in_ready looks only at stored state, so a pop never opens the write port in the same cycle.
   assign in_ready = !full && !rst;
   assign wr_en    = in_valid && in_ready && !flush;
   // Reading requires a word already stored, so a word is never read in the cycle it is written.
   assign rd_en    = out_ready && !empty && !flush && !rst;

   always_comb begin
      level_next = level;
      if (rst || flush) begin
         level_next = '0;
      end else if (wr_en && !rd_en) begin
         level_next = level + PW'(1);
      end else if (rd_en && !wr_en) begin
         level_next = level - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level_next;
   end

   // Storage is cleared on rst only, so the fall-through output reads 0 after reset;
   // flush leaves contents in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   assign almost_full  = (level >= AFULL_LV);
   assign almost_empty = (level <= AEMPTY_LV);

   if (FWFT != 0) begin : g_fwft
      assign out_valid = !empty;
      assign out_data  = mem[rd_ptr[AW-1:0]];
   end else begin : g_reg
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= rd_en;
            if (rd_en) data_q <= mem[rd_ptr[AW-1:0]];
         end
      end
      assign out_valid = valid_q;
      assign out_data  = data_q;
   end

`ifdef FIFO_HWM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hwm <= '0;
      end else if (flush || hwm_clr) begin
         hwm <= level_next;
      end else if (level_next > hwm) begin
         hwm <= level_next;
      end
   end
`endif

endmodule
